// File: rtl/alu_seq_pkg.sv
// Shared types for the alu sequencer slice.
// Op codes and sequencer state encoding.
package alu_seq_pkg;

  localparam logic [3:0] OP_NO  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MLOOP = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational op decode with a registered
// result: one cycle from inputs to o_data.
module alu
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] res;

  // Decode the op; anything unrecognised yields zero.
  always_comb begin
    res = '0;
    case (i_op)
      OP_ADD:  res = i_a + i_b;
      OP_SUB:  res = i_a - i_b;
      OP_AND:  res = i_a & i_b;
      OP_OR:   res = i_a | i_b;
      OP_XOR:  res = i_a ^ i_b;
      OP_ROL:  res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      default: res = '0;
    endcase
  end

  // Register the result to give the fixed 1-cycle latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_data <= '0;
    else          o_data <= res;
  end

endmodule

// File: rtl/alu_seq.sv
// Request/response sequencer around the alu;
// adds shift-add MUL built on alu ADD.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_state_t       state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             ph_q;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_q;
  logic             accept, mul_last;

  assign accept   = i_req_valid && (state == ST_IDLE);
  assign mul_last = (state == ST_MLOOP) && ph_q && (cnt_q == LAST);

  // MUL borrows the alu as an adder: acc + mcand.
  always_comb begin
    alu_op = op_q;
    alu_a  = a_q;
    alu_b  = b_q;
    if (state == ST_MLOOP) begin
      alu_op = OP_ADD;
      alu_a  = acc_q;
      alu_b  = a_q;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_op    (alu_op),
    .i_a     (alu_a),
    .i_b     (alu_b),
    .o_data  (alu_q)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid)
          state_nxt = (i_op == OP_MUL) ? ST_MLOOP : ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_RESP;
      ST_MLOOP: if (mul_last) state_nxt = ST_RESP;
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, multiply iteration, result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      ph_q   <= 1'b0;
      o_data <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      a_q   <= i_arg0;
      b_q   <= i_arg1;
      acc_q <= '0;
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else if (state == ST_WAIT) begin
      o_data <= alu_q;
    end else if (state == ST_MLOOP) begin
      ph_q <= ~ph_q;
      if (ph_q) begin
        if (b_q[0]) acc_q <= alu_q;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        if (mul_last) o_data <= b_q[0] ? alu_q : acc_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8).
// Checks latency, data, backpressure, resets.
module tb_alu_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic [3:0] i_op = 4'h0;
  logic [7:0] i_arg0 = 8'h00;
  logic [7:0] i_arg1 = 8'h00;
  logic       o_rsp_valid;
  logic       i_rsp_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_op        (i_op),
    .i_arg0      (i_arg0),
    .i_arg1      (i_arg1),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_data      (o_data),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string tag,
                         input logic [3:0] op,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [7:0] exp,
                         input int lat,
                         input int hold);
    int n;
    n = 0;
    while (!o_req_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " req_rdy"}, o_req_ready, 1);
    i_req_valid = 1'b1;
    i_op = op;
    i_arg0 = a;
    i_arg1 = b;
    tick();
    i_req_valid = 1'b0;
    i_op = 4'h1;
    i_arg0 = 8'($urandom);
    i_arg1 = 8'($urandom);
    chk({tag, " busy"}, {o_busy, o_req_ready}, 2'b10);
    n = 1;
    while (!o_rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " data"}, o_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold"},
          {o_rsp_valid, o_req_ready, o_data},
          {1'b1, 1'b0, exp});
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk({tag, " post"},
        {o_req_ready, o_rsp_valid, o_busy, o_data},
        {1'b1, 1'b0, 1'b0, exp});
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    chk("reset",
        {o_req_ready, o_rsp_valid, o_busy, o_data},
        {1'b1, 1'b0, 1'b0, 8'h00});
    i_rst_n = 1'b1;
    tick();

    run_req("add",  4'h1, 8'hF0, 8'h20, 8'h10, 3, 0);
    run_req("mul1", 4'h3, 8'd13, 8'd11, 8'h8F, 17, 0);
    run_req("mul2", 4'h3, 8'hFF, 8'hFF, 8'h01, 17, 0);
    run_req("mul0", 4'h3, 8'h00, 8'h5A, 8'h00, 17, 0);
    run_req("sub",  4'h2, 8'h05, 8'h07, 8'hFE, 3, 5);
    run_req("rol",  4'h7, 8'h81, 8'h01, 8'h03, 3, 0);
    run_req("unk",  4'hF, 8'h12, 8'h34, 8'h00, 3, 0);
    run_req("xor",  4'h6, 8'hAA, 8'hFF, 8'h55, 3, 0);

    i_req_valid = 1'b1;
    i_op = 4'h3;
    i_arg0 = 8'h7F;
    i_arg1 = 8'h33;
    tick();
    i_req_valid = 1'b0;
    repeat (8) tick();
    chk("mid busy", o_busy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid rst",
        {o_req_ready, o_rsp_valid, o_busy, o_data},
        {1'b1, 1'b0, 1'b0, 8'h00});
    tick();
    i_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_rsp_valid || !o_req_ready) seen++;
    end
    chk("no stale", seen, 0);
    run_req("and",  4'h4, 8'h3C, 8'h0F, 8'h0C, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
